param_update_sequencer: RTL and testbench
=========================================

Name: param_update_sequencer

Overview:
FSM controller sequencing the parameter-register/mux datapath of the training engine. Per run it loads the initial W/b set once, then for each sample:
- runs a forward pass of fixed latency;
- waits for backprop results layer 3→2→1;
- strobes the matching update-register enables;
- switches the parameter mux to the updated set.
It iterates samples and epochs, then reports done. It replaces the free-running count-based mux timing with an explicit handshake-driven schedule.

Parameters:
FWD_LATENCY, 6, cycles the forward pass needs per sample (≥1)
N_SAMPLES, 10, samples per epoch (≥1)
N_EPOCHS, 1, epochs per run (≥1)
TIMEOUT, 64, max cycles waiting for bwd_ack (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
start  in  1  begin a run; sampled in IDLE or DONE
abort  in  1  return to IDLE from any state
bwd_ack  in  1  backprop result for current layer valid this cycle
enable_initial  out  1  load strobe for initial-parameter registers
enable_update_layer_1  out  1  update-register strobe, layer 1
enable_update_layer_2  out  1  update-register strobe, layer 2
enable_update_layer_3  out  1  update-register strobe, layer 3
block_reset  out  1  clears update registers (ORed with reset downstream)
select  out  1  parameter mux: 0 = initial set, 1 = updated set
fwd_enable  out  1  forward pass active
busy  out  1  state ≠ IDLE and ≠ DONE
done  out  1  high in DONE
sample_idx  out  32  current sample
epoch_idx  out  32  current epoch
error  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset=0): state IDLE, counters 0, select 0, error 0. All outputs 0.
- Timing: strobes and flags are decoded from the state register (Moore). A transition on edge k is visible in cycle k+1.
- States: IDLE, LOAD, FWD, UPD3, UPD2, UPD1, NEXT, DONE.
- IDLE: start → LOAD.
- LOAD: exactly one cycle. enable_initial=1 and block_reset=1. select cleared to 0. sample_idx=epoch_idx=0. → FWD.
- FWD: fwd_enable=1 for exactly FWD_LATENCY cycles via cycle counter 0..FWD_LATENCY-1; at terminal count → UPD3.
- UPD3/UPD2/UPD1: wait for bwd_ack.
  - In the ack cycle, enable_update_layer_n=1 (combinational with bwd_ack, state-qualified).
  - Next state UPD2, UPD1, NEXT respectively.
  - Leaving UPD1 sets select=1, sticky until next LOAD or abort.
- bwd_ack outside UPD* states: ignored.
- NEXT: one cycle. sample_idx+1.
  - If sample_idx==N_SAMPLES-1: sample_idx wraps to 0 and epoch_idx+1.
  - If additionally epoch_idx==N_EPOCHS-1 → DONE (indices hold final values), else → FWD.
- DONE: done=1 held. start → LOAD (restart); otherwise stay.
- abort, any state except IDLE: → IDLE next edge. block_reset=1 for that one IDLE-entry cycle, select=0, counters 0. abort in IDLE: no effect.
- Simultaneous start and abort: abort wins.
- start while busy: ignored.

Optional Feature:
UPDATE_TIMEOUT_EN
- Defined: a wait counter runs in each UPD* state and restarts on entry. If TIMEOUT cycles elapse without bwd_ack, error is set (sticky until reset or next LOAD) and the abort path is taken (→ IDLE, block_reset pulse).
- Undefined: UPD* waits indefinitely; error tied 0; TIMEOUT unused.

Decomposition:
- State enum typedef (seq_state_t) goes in the shared typedef header.
- L1..L4 and data_type remain in the forward-net header; this block needs none of them.
- One sub-module: cycle_counter (clear, enable, terminal-count compare, 32-bit), instantiated for the FWD count and the timeout count.

Test Plan:
- Reset held low mid-FWD → all outputs 0 immediately (asynchronous); after release, state is IDLE and select=0.
- FWD_LATENCY=6, N_SAMPLES=1, N_EPOCHS=1; start at cycle 0, bwd_ack asserted every UPD cycle → enable_initial in cycle 1, fwd_enable cycles 2–7, enable_update_layer_3/2/1 in cycles 8/9/10, select=1 from cycle 11, done from cycle 12.
- bwd_ack delayed 5 cycles in UPD2 → enable_update_layer_2 only in the ack cycle, layer 1 strobe never precedes it, fwd_enable stays 0 throughout.
- N_SAMPLES=2, N_EPOCHS=2 → four FWD phases; sample_idx sequence 0,1,0,1; epoch_idx 0,0,1,1; done after the fourth UPD1; select stays 1 across the epoch boundary.
- abort and start together during UPD2 → IDLE next cycle, block_reset one cycle, select=0, no layer strobes; a later start re-runs from LOAD.
- With UPDATE_TIMEOUT_EN and TIMEOUT=4, no bwd_ack in UPD3 → error=1 after 4 cycles, state IDLE, block_reset pulse. Without the macro the same stimulus stays in UPD3 with error=0.

Source files
------------

// File: rtl/param_update_sequencer_pkg.sv
// Shared types and constants for the parameter-update sequencer.
// The state type is a plain 3-bit vector with named constants so legacy code can compare encodings directly.
package param_update_sequencer_pkg;

  localparam int unsigned CNT_W = 32;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t S_IDLE = 3'd0;
  localparam seq_state_t S_LOAD = 3'd1;
  localparam seq_state_t S_FWD  = 3'd2;
  localparam seq_state_t S_UPD3 = 3'd3;
  localparam seq_state_t S_UPD2 = 3'd4;
  localparam seq_state_t S_UPD1 = 3'd5;
  localparam seq_state_t S_NEXT = 3'd6;
  localparam seq_state_t S_DONE = 3'd7;

  // True in any of the three states that wait for a backprop result.
  function automatic logic is_upd(input seq_state_t s);
    return (s == S_UPD3) || (s == S_UPD2) || (s == S_UPD1);
  endfunction

endpackage

// File: rtl/param_update_sequencer_cycle_counter.sv
// Clearable up-counter that flags when its count equals a terminal value.
// The same block times both the forward pass and the backprop wait.
module param_update_sequencer_cycle_counter
  import param_update_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count_r;

  // Count register; clear has priority over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + WIDTH'(1'b1);
    end
  end

  assign tc = (count_r == terminal);

endmodule

// File: rtl/param_update_sequencer.sv
// Handshake-driven scheduler for the training engine's parameter registers and mux.
// Optional backprop watchdog: define UPDATE_TIMEOUT_EN to enable the TIMEOUT-cycle wait limit.
module param_update_sequencer
  import param_update_sequencer_pkg::*;
#(
  parameter int unsigned FWD_LATENCY = 6,
  parameter int unsigned N_SAMPLES   = 10,
  parameter int unsigned N_EPOCHS    = 1,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        bwd_ack,
  output logic        enable_initial,
  output logic        enable_update_layer_1,
  output logic        enable_update_layer_2,
  output logic        enable_update_layer_3,
  output logic        block_reset,
  output logic        select,
  output logic        fwd_enable,
  output logic        busy,
  output logic        done,
  output logic [31:0] sample_idx,
  output logic [31:0] epoch_idx,
  output logic        error
);

  if ((FWD_LATENCY < 32'd1) || (N_SAMPLES < 32'd1) || (N_EPOCHS < 32'd1) || (TIMEOUT < 32'd1)) begin : g_param_check
    $error("param_update_sequencer: all parameters must be >= 1");
  end

  seq_state_t  state_r;
  seq_state_t  state_nxt_s;
  logic        select_r;
  logic        abort_pulse_r;
  logic [31:0] sample_r;
  logic [31:0] epoch_r;
  logic        abort_s;
  logic        timeout_s;
  logic        upd_s;
  logic        fwd_s;
  logic        fwd_tc_s;
  logic        last_sample_s;
  logic        last_epoch_s;
  logic        load_entry_s;

  assign upd_s         = is_upd(state_r);
  assign fwd_s         = (state_r == S_FWD);
  assign abort_s       = abort && (state_r != S_IDLE);
  assign last_sample_s = (sample_r == 32'(N_SAMPLES - 32'd1));
  assign last_epoch_s  = (epoch_r == 32'(N_EPOCHS - 32'd1));
  assign load_entry_s  = (state_nxt_s == S_LOAD) && (state_r != S_LOAD);

  param_update_sequencer_cycle_counter #(.WIDTH(CNT_W)) u_fwd_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (!fwd_s),
    .enable   (fwd_s),
    .terminal (32'(FWD_LATENCY - 32'd1)),
    .tc       (fwd_tc_s)
  );

`ifdef UPDATE_TIMEOUT_EN
  logic to_tc_s;
  logic error_r;

  // An ack restarts the wait window, so each layer gets a fresh TIMEOUT budget.
  param_update_sequencer_cycle_counter #(.WIDTH(CNT_W)) u_to_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (!upd_s || bwd_ack),
    .enable   (upd_s),
    .terminal (32'(TIMEOUT - 32'd1)),
    .tc       (to_tc_s)
  );

  assign timeout_s = upd_s && !bwd_ack && to_tc_s;

  // Sticky watchdog flag, cleared only by a fresh run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_r <= 1'b0;
    end else if (timeout_s) begin
      error_r <= 1'b1;
    end else if (load_entry_s) begin
      error_r <= 1'b0;
    end
  end

  assign error = error_r;
`else
  assign timeout_s = 1'b0;
  assign error     = 1'b0;
`endif

  // Next-state selection; abort and watchdog expiry override the schedule.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s || timeout_s) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  if (start) state_nxt_s = S_LOAD; else state_nxt_s = S_IDLE;
        S_LOAD:  state_nxt_s = S_FWD;
        S_FWD:   if (fwd_tc_s) state_nxt_s = S_UPD3; else state_nxt_s = S_FWD;
        S_UPD3:  if (bwd_ack) state_nxt_s = S_UPD2; else state_nxt_s = S_UPD3;
        S_UPD2:  if (bwd_ack) state_nxt_s = S_UPD1; else state_nxt_s = S_UPD2;
        S_UPD1:  if (bwd_ack) state_nxt_s = S_NEXT; else state_nxt_s = S_UPD1;
        S_NEXT:  if (last_sample_s && last_epoch_s) state_nxt_s = S_DONE; else state_nxt_s = S_FWD;
        S_DONE:  if (start) state_nxt_s = S_LOAD; else state_nxt_s = S_DONE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // State, mux select, abort pulse and sample/epoch indices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      select_r      <= 1'b0;
      abort_pulse_r <= 1'b0;
      sample_r      <= 32'd0;
      epoch_r       <= 32'd0;
    end else begin
      state_r       <= state_nxt_s;
      abort_pulse_r <= abort_s || timeout_s;
      if (abort_s || timeout_s || load_entry_s) begin
        select_r <= 1'b0;
        sample_r <= 32'd0;
        epoch_r  <= 32'd0;
      end else if ((state_r == S_UPD1) && bwd_ack) begin
        select_r <= 1'b1;
      end else if (state_r == S_NEXT) begin
        if (last_sample_s) begin
          sample_r <= 32'd0;
          epoch_r  <= epoch_r + 32'd1;
        end else begin
          sample_r <= sample_r + 32'd1;
        end
      end
    end
  end

  assign enable_initial        = (state_r == S_LOAD);
  assign block_reset           = (state_r == S_LOAD) || abort_pulse_r;
  assign fwd_enable            = fwd_s;
  assign enable_update_layer_3 = (state_r == S_UPD3) && bwd_ack;
  assign enable_update_layer_2 = (state_r == S_UPD2) && bwd_ack;
  assign enable_update_layer_1 = (state_r == S_UPD1) && bwd_ack;
  assign select                = select_r;
  assign busy                  = (state_r != S_IDLE) && (state_r != S_DONE);
  assign done                  = (state_r == S_DONE);
  assign sample_idx            = sample_r;
  assign epoch_idx             = epoch_r;

endmodule

// File: tb/tb_param_update_sequencer.sv
// Self-checking bench: scripted per-run schedule with random ack delays, random aborts and ignored inputs.
module tb_param_update_sequencer;

  localparam int FWD = 6;
  localparam int NS  = 2;
  localparam int NE  = 2;
  localparam int TO  = 4;
`ifdef UPDATE_TIMEOUT_EN
  localparam int MAXD = 3;
`else
  localparam int MAXD = 6;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        bwd_ack;
  logic        enable_initial;
  logic        enable_update_layer_1;
  logic        enable_update_layer_2;
  logic        enable_update_layer_3;
  logic        block_reset;
  logic        select;
  logic        fwd_enable;
  logic        busy;
  logic        done;
  logic [31:0] sample_idx;
  logic [31:0] epoch_idx;
  logic        error;
  logic [9:0]  obs;

  int errors = 0;
  int checks = 0;

  // Expected sticky values and run bookkeeping.
  bit exp_sel  = 1'b0;
  bit exp_err  = 1'b0;
  bit exp_done = 1'b0;
  int exp_s    = 0;
  int exp_e    = 0;
  int rc       = 0;
  int abort_at = -1;
  bit abort_start = 1'b0;
  bit aborted  = 1'b0;

  param_update_sequencer #(
    .FWD_LATENCY (FWD),
    .N_SAMPLES   (NS),
    .N_EPOCHS    (NE),
    .TIMEOUT     (TO)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .abort                 (abort),
    .bwd_ack               (bwd_ack),
    .enable_initial        (enable_initial),
    .enable_update_layer_1 (enable_update_layer_1),
    .enable_update_layer_2 (enable_update_layer_2),
    .enable_update_layer_3 (enable_update_layer_3),
    .block_reset           (block_reset),
    .select                (select),
    .fwd_enable            (fwd_enable),
    .busy                  (busy),
    .done                  (done),
    .sample_idx            (sample_idx),
    .epoch_idx             (epoch_idx),
    .error                 (error)
  );

  assign obs = {enable_initial, enable_update_layer_1, enable_update_layer_2, enable_update_layer_3,
                block_reset, select, fwd_enable, busy, done, error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Expected output vector; select and error come from the tracked sticky values.
  function automatic logic [9:0] ev(input bit ei, input bit l1, input bit l2, input bit l3,
                                    input bit br, input bit fwd, input bit bsy, input bit dn);
    return {ei, l1, l2, l3, br, exp_sel, fwd, bsy, dn, exp_err};
  endfunction

  // One clock cycle: optionally inject the abort, compare mid-cycle, advance.
  task automatic cyc(input string tag, input logic [9:0] expv);
    logic [9:0] want;
    bit ab;
    ab   = (rc == abort_at);
    want = expv;
    if (ab) begin
      abort   = 1'b1;
      start   = abort_start;
      bwd_ack = 1'b0;
      want[8:6] = 3'b000;
    end
    @(negedge clk);
    check_val(tag, 32'(obs), 32'(want));
    check_val({tag, "_sidx"}, sample_idx, 32'(exp_s));
    check_val({tag, "_eidx"}, epoch_idx, 32'(exp_e));
    @(posedge clk);
    #1;
    rc++;
    if (ab) begin
      abort    = 1'b0;
      start    = 1'b0;
      aborted  = 1'b1;
      exp_sel  = 1'b0;
      exp_done = 1'b0;
      exp_s    = 0;
      exp_e    = 0;
      @(negedge clk);
      check_val("abort_idle", 32'(obs), 32'(ev(0, 0, 0, 0, 1, 0, 0, 0)));
      check_val("abort_sidx", sample_idx, 32'd0);
      check_val("abort_eidx", epoch_idx, 32'd0);
      @(posedge clk);
      #1;
      check_val("abort_pulse_end", 32'(block_reset), 32'd0);
    end
  endtask

  task automatic run(input bit zero_delay, input int ab_at, input bit ab_start, input bit ab_l2);
    int d;
    rc = 0; abort_at = ab_at; abort_start = ab_start; aborted = 1'b0;
    start = 1'b1;
    cyc("start", ev(0, 0, 0, 0, 0, 0, 0, exp_done));
    start = 1'b0;
    if (aborted) return;
    exp_sel = 1'b0; exp_err = 1'b0; exp_done = 1'b0; exp_s = 0; exp_e = 0;
    cyc("load", ev(1, 0, 0, 0, 1, 0, 1, 0));
    if (aborted) return;
    for (int ep = 0; ep < NE; ep++) begin
      for (int sm = 0; sm < NS; sm++) begin
        exp_s = sm; exp_e = ep;
        for (int k = 0; k < FWD; k++) begin
          bwd_ack = 1'($urandom_range(0, 1));
          start   = 1'($urandom_range(0, 1));
          cyc("fwd", ev(0, 0, 0, 0, 0, 1, 1, 0));
          bwd_ack = 1'b0; start = 1'b0;
          if (aborted) return;
        end
        for (int l = 3; l >= 1; l--) begin
          d = zero_delay ? 0 : int'($urandom_range(0, MAXD));
          if (ab_l2 && l == 2 && ep == 0 && sm == 0) begin
            abort_at = rc + d / 2; abort_start = 1'b1;
          end
          for (int w = 0; w < d; w++) begin
            start = 1'($urandom_range(0, 1));
            cyc("upd_wait", ev(0, 0, 0, 0, 0, 0, 1, 0));
            start = 1'b0;
            if (aborted) return;
          end
          bwd_ack = 1'b1;
          cyc("upd_ack", ev(0, l == 1, l == 2, l == 3, 0, 0, 1, 0));
          bwd_ack = 1'b0;
          if (aborted) return;
          if (l == 1) exp_sel = 1'b1;
        end
        bwd_ack = 1'($urandom_range(0, 1));
        cyc("next", ev(0, 0, 0, 0, 0, 0, 1, 0));
        bwd_ack = 1'b0;
        if (aborted) return;
      end
    end
    exp_done = 1'b1; exp_s = 0; exp_e = NE;
    for (int k = 0; k < 2; k++) begin
      bwd_ack = 1'($urandom_range(0, 1));
      cyc("done", ev(0, 0, 0, 0, 0, 0, 0, 1));
      bwd_ack = 1'b0;
    end
  endtask

  task automatic timeout_run();
    rc = 0; abort_at = -1; aborted = 1'b0;
    start = 1'b1;
    cyc("to_start", ev(0, 0, 0, 0, 0, 0, 0, exp_done));
    start = 1'b0;
    exp_sel = 1'b0; exp_err = 1'b0; exp_done = 1'b0; exp_s = 0; exp_e = 0;
    cyc("to_load", ev(1, 0, 0, 0, 1, 0, 1, 0));
    for (int k = 0; k < FWD; k++) cyc("to_fwd", ev(0, 0, 0, 0, 0, 1, 1, 0));
`ifdef UPDATE_TIMEOUT_EN
    for (int w = 0; w < TO; w++) cyc("to_wait", ev(0, 0, 0, 0, 0, 0, 1, 0));
    exp_err = 1'b1;
    @(negedge clk);
    check_val("to_idle", 32'(obs), 32'(ev(0, 0, 0, 0, 1, 0, 0, 0)));
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("to_idle_hold", 32'(obs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk);
    #1;
`else
    for (int w = 0; w < 5 * TO; w++) cyc("to_hold", ev(0, 0, 0, 0, 0, 0, 1, 0));
    abort_at = rc;
    cyc("to_abort", ev(0, 0, 0, 0, 0, 0, 1, 0));
`endif
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; bwd_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", 32'(obs), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b1;
    cyc("idle_abort_ignored", ev(0, 0, 0, 0, 0, 0, 0, 0));
    abort = 1'b0;
    cyc("reset_state", ev(0, 0, 0, 0, 0, 0, 0, 0));

    run(1'b1, -1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(0, 1) == 1) run(1'b0, int'($urandom_range(1, 60)), 1'($urandom_range(0, 1)), 1'b0);
      else run(1'b0, -1, 1'b0, 1'b0);
    end
    run(1'b0, -1, 1'b0, 1'b1);
    run(1'b0, -1, 1'b0, 1'b0);
    timeout_run();
    run(1'b0, -1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a forward pass.
    rc = 0; abort_at = -1; aborted = 1'b0;
    start = 1'b1;
    cyc("mr_start", ev(0, 0, 0, 0, 0, 0, 0, exp_done));
    start = 1'b0;
    exp_sel = 1'b0; exp_err = 1'b0; exp_done = 1'b0; exp_s = 0; exp_e = 0;
    cyc("mr_load", ev(1, 0, 0, 0, 1, 0, 1, 0));
    for (int k = 0; k < 3; k++) cyc("mr_fwd", ev(0, 0, 0, 0, 0, 1, 1, 0));
    #1;
    reset = 1'b0;
    #1;
    check_val("mr_async_outputs", 32'(obs), 32'd0);
    check_val("mr_async_sidx", sample_idx, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("mr_idle", ev(0, 0, 0, 0, 0, 0, 0, 0));
    cyc("mr_idle2", ev(0, 0, 0, 0, 0, 0, 0, 0));
    run(1'b0, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
